// File: rtl/inv_arbiter.sv
// ---------------------------------------------------------------------------
// inv_arbiter
//
// Round-robin arbiter and sequencer sharing one `inv` datapath instance
// (inputs X1/X2/X3, output Y1) among NUM_REQ requesters. An accepted request
// drives its 3-bit operand onto the shared unit. A tag pipeline matched to
// the unit latency carries the requester id alongside the operation, and the
// sampled Y1 is returned to the originating requester.
//
// Parameters
//   NUM_REQ  number of requesters (2..8)
//   DUT_LAT  edges from an X change until Y1 is valid (0 = combinational inv,
//            1 = registered inv)
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   en         arbitration enable; low blocks new grants
//   req_valid  per-requester request valid
//   req_x      operand of requester i at [3i+2:3i] (bit0->X1, bit1->X2, bit2->X3)
//   req_ready  one-hot grant (combinational)
//   rsp_valid  one-hot response strobe, one cycle
//   rsp_y      Y1 result for the strobed requester
//   inv_x1..3  registered drive to the inv X1/X2/X3 inputs
//   inv_y1     inv Y1 output
//   idle       high when no operation is in flight
// ---------------------------------------------------------------------------
module inv_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DUT_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [3*NUM_REQ-1:0]   req_x,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic                   rsp_y,
    output logic                   inv_x1,
    output logic                   inv_x2,
    output logic                   inv_x3,
    input  logic                   inv_y1,
    output logic                   idle
);

    localparam int PW    = $clog2(NUM_REQ);
    localparam int DEPTH = DUT_LAT + 1;

    typedef struct packed {
        logic          valid;
        logic [PW-1:0] id;
    } tag_t;

    logic [PW-1:0]      ptr_q;
    tag_t               tag_q [DEPTH];

    logic               grant_found;
    logic [PW-1:0]      grant_id;
    logic               xfer;
    logic [2:0]         grant_x;
    logic [NUM_REQ-1:0] rsp_onehot;
    logic               any_inflight;

    // Round-robin search starting at the priority pointer and wrapping.
    // NOTE: every signal driven here gets a default first so no path through
    // the block leaves it unassigned; otherwise a latch would be inferred.
    always_comb begin : arb_search
        int cand;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!grant_found && req_valid[PW'(cand)]) begin
                grant_found = 1'b1;
                grant_id    = PW'(cand);
            end
        end
    end

    // A grant is only offered while enabled and out of reset; since ready
    // implies valid, an offered grant is a transfer at the next edge.
    assign xfer = grant_found & en & rst_n;

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[grant_id] = 1'b1;
    end

    // Operand of the granted requester.
    always_comb begin
        grant_x = 3'b000;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == PW'(k)) grant_x = req_x[3*k +: 3];
        end
    end

    // Id carried by the last tag stage, expanded to the response strobe.
    always_comb begin
        rsp_onehot = '0;
        rsp_onehot[tag_q[DEPTH-1].id] = 1'b1;
    end

    always_comb begin
        any_inflight = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            any_inflight = any_inflight | tag_q[s].valid;
        end
    end

    assign idle = !any_inflight && (rsp_valid == '0);

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the tag stages shift correctly regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            inv_x1    <= 1'b0;
            inv_x2    <= 1'b0;
            inv_x3    <= 1'b0;
            rsp_valid <= '0;
            rsp_y     <= 1'b0;
            // NOTE: the tag pipeline is a handful of flops, not a memory, so
            // it is reset; clearing the valid bits is what discards in-flight
            // operations when reset hits mid-operation.
            for (int s = 0; s < DEPTH; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            if (xfer) begin
                ptr_q <= (grant_id == PW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                {inv_x3, inv_x2, inv_x1} <= grant_x;
            end

            tag_q[0] <= xfer ? '{valid: 1'b1, id: grant_id} : '0;
            for (int s = 1; s < DEPTH; s++) begin
                tag_q[s] <= tag_q[s-1];
            end

            // The last stage becomes valid exactly when inv_y1 reflects the
            // operand issued DUT_LAT+1 edges earlier.
            if (tag_q[DEPTH-1].valid) begin
                rsp_valid <= rsp_onehot;
                rsp_y     <= inv_y1;
            end else begin
                rsp_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_inv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_inv_arbiter
//
// Directed bench for inv_arbiter with a registered inv model (DUT_LAT = 1).
// The stimulus side computes the expected grant from its own round-robin
// pointer and queues the expected response; an independent monitor pops and
// compares whenever rsp_valid fires, including the arrival cycle.
// ---------------------------------------------------------------------------
module tb_inv_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DUT_LAT = 1;
    localparam int TIMEOUT = 200;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic [NUM_REQ-1:0]   req_valid;
    logic [3*NUM_REQ-1:0] req_x;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic                 rsp_y;
    logic                 inv_x1, inv_x2, inv_x3;
    logic                 inv_y1;
    logic                 idle;

    inv_arbiter #(.NUM_REQ(NUM_REQ), .DUT_LAT(DUT_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .inv_x1    (inv_x1),
        .inv_x2    (inv_x2),
        .inv_x3    (inv_x3),
        .inv_y1    (inv_y1),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered inv model: Y1 = NOT(X1 xor X2 xor X3), one edge of latency.
    initial inv_y1 = 1'b0;
    always @(posedge clk) inv_y1 <= ~(inv_x1 ^ inv_x2 ^ inv_x3);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [NUM_REQ-1:0] onehot;
        logic               y;
        int                 due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (req_ready != '0) check("ready_onehot", 32'($onehot(req_ready)), 1);
        if (rsp_valid != '0) begin
            check("rsp_onehot", 32'($onehot(rsp_valid)), 1);
            if (sb.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_id", rsp_valid, mon_e.onehot);
                check("rsp_y", rsp_y, mon_e.y);
                check("rsp_cycle", cyc, mon_e.due);
            end
        end else if (sb.size() != 0 && cyc >= sb[0].due) begin
            mon_e = sb.pop_front();
            check("rsp_missing", rsp_valid, mon_e.onehot);
        end
    end

    // ---------------- requester model ----------------
    logic [2:0]         op_tab [NUM_REQ][8];
    int                 op_cnt [NUM_REQ];
    int                 op_idx [NUM_REQ];
    int                 m_ptr;
    logic [NUM_REQ-1:0] last_ready;

    task automatic clear_ops();
        for (int i = 0; i < NUM_REQ; i++) begin
            op_cnt[i] = 0;
            op_idx[i] = 0;
        end
    endtask

    task automatic add_op(input int i, input logic [2:0] x);
        op_tab[i][op_cnt[i]] = x;
        op_cnt[i]++;
    endtask

    function automatic logic pending();
        logic p = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) if (op_idx[i] < op_cnt[i]) p = 1'b1;
        return p;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]   = (op_idx[i] < op_cnt[i]);
            req_x[3*i +: 3] = req_valid[i] ? op_tab[i][op_idx[i]] : 3'b000;
        end
    endtask

    function automatic int model_grant();
        int c;
        if (!en || !rst_n) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            c = (m_ptr + k) % NUM_REQ;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    // One cycle: entered just after a rising edge, returns just after the next.
    task automatic step();
        int                 g;
        logic [NUM_REQ-1:0] exp_ready;
        logic [2:0]         opx;
        drive_inputs();
        @(negedge clk);
        g         = model_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        last_ready = req_ready;
        if (g >= 0) begin
            opx = req_x[3*g +: 3];
            sb.push_back('{onehot: exp_ready, y: ~(^opx), due: cyc + DUT_LAT + 2});
        end
        @(posedge clk);
        if (g >= 0) m_ptr = (g + 1) % NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && last_ready[i]) op_idx[i]++;
        end
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || pending()) && k < TIMEOUT) begin
            step();
            k++;
        end
        if (k >= TIMEOUT) check("drain_timeout", 0, 1);
        check("idle_after_drain", idle, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        req_x     = '0;
        m_ptr     = 0;
        clear_ops();
        #2;
        check("reset_outputs", {req_ready, rsp_valid, rsp_y, inv_x3, inv_x2, inv_x1, idle},
              {{NUM_REQ{1'b0}}, {NUM_REQ{1'b0}}, 5'b00001});
        en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset/idle: 20 quiet cycles.
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_outputs", {req_ready, rsp_valid, rsp_y, inv_x3, inv_x2, inv_x1, idle},
                  {{NUM_REQ{1'b0}}, {NUM_REQ{1'b0}}, 5'b00001});
        end

        // Single op: requester 2, operand 101 -> Y1 = ~(1^0^1) = 1.
        add_op(2, 3'b101);
        step();
        check("single_ready", last_ready, 4'b0100);
        check("single_inv_x", {inv_x3, inv_x2, inv_x1}, 3'b101);
        check("single_busy", idle, 0);
        drain();

        // Pointer rotation: pointer is 3; grant 3, then 0 before 2.
        clear_ops();
        add_op(3, 3'b011);
        step();
        check("rot_g3", last_ready, 4'b1000);
        add_op(0, 3'b110);
        add_op(2, 3'b001);
        step();
        check("rot_first", last_ready, 4'b0001);
        step();
        check("rot_second", last_ready, 4'b0100);
        drain();

        // One op on 3 brings the pointer to 0 for the fairness run.
        clear_ops();
        add_op(3, 3'b111);
        step();
        check("pre_rr_g3", last_ready, 4'b1000);
        drain();

        // Fairness: all four valid, three distinct operands each.
        clear_ops();
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < 3; j++) add_op(i, 3'(i*3 + j));
        end
        for (int k = 0; k < 12; k++) begin
            step();
            check("rr_grant", last_ready, 32'(1) << (k % 4));
        end
        drain();

        // Enable gating: three grants, then en low with requester 0 still valid.
        clear_ops();
        add_op(0, 3'b110);
        add_op(0, 3'b011);
        add_op(1, 3'b001);
        add_op(2, 3'b111);
        step();
        step();
        step();
        check("en_third_grant", last_ready, 4'b0100);
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check("en_low_ready", last_ready, 4'b0000);
        end
        check("en_low_idle", idle, 1);
        check("en_low_hold_x", {inv_x3, inv_x2, inv_x1}, 3'b111);
        add_op(3, 3'b010);
        en = 1'b1;
        step();
        check("en_resume_ptr", last_ready, 4'b1000);
        step();
        check("en_resume_next", last_ready, 4'b0001);
        drain();

        // Reset mid-operation: pointer is 1; grant 1 and 2, then pulse reset.
        clear_ops();
        add_op(1, 3'b100);
        add_op(2, 3'b011);
        step();
        check("rst_pre_g1", last_ready, 4'b0010);
        step();
        check("rst_pre_g2", last_ready, 4'b0100);
        rst_n = 1'b0;
        sb.delete();
        m_ptr = 0;
        clear_ops();
        drive_inputs();
        #2;
        check("rst_mid_outputs", {rsp_valid, inv_x3, inv_x2, inv_x1, idle},
              {{NUM_REQ{1'b0}}, 4'b0001});
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_post_quiet", {rsp_valid, idle}, {{NUM_REQ{1'b0}}, 1'b1});
        end
        check("rst_post_inv_x", {inv_x3, inv_x2, inv_x1}, 3'b000);
        add_op(1, 3'b100);
        add_op(3, 3'b001);
        step();
        check("rst_post_g1", last_ready, 4'b0010);
        step();
        check("rst_post_g3", last_ready, 4'b1000);
        drain();

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_arbiter.md
Name: inv_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one `inv` datapath instance (inputs X1/X2/X3, output Y1) among NUM_REQ requesters.
- Each accepted request drives one 3-bit operand onto the shared unit. The block tracks the in-flight operation through a tag pipeline matched to the unit's latency, and returns the sampled Y1 to the originating requester.
- It sits between the requester logic and the `inv` instance; the `inv` clock is shared.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DUT_LAT, 1, edges from X change until Y1 is valid (0 = combinational inv, 1 = registered inv).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; low blocks new grants.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_x  input  3*NUM_REQ  operand of requester i at bits [3i+2:3i]; bit 0 maps to X1, bit 1 to X2, bit 2 to X3.
- req_ready  output  NUM_REQ  one-hot grant (combinational).
- rsp_valid  output  NUM_REQ  one-hot response strobe, one cycle.
- rsp_y  output  1  Y1 result for the strobed requester.
- inv_x1, inv_x2, inv_x3  output  1 each  registered drive to the `inv` X1/X2/X3.
- inv_y1  input  1  `inv` Y1.
- idle  output  1  high when no operation is in flight.

Behaviour:
- Reset (rst_n low, asynchronous):
  - inv_x* = 0, rsp_valid = 0, rsp_y = 0, req_ready = 0.
  - Tag pipeline cleared, priority pointer = 0, idle = 1.
  - Reset asserted mid-operation discards all in-flight results; no rsp_valid is ever produced for them.
- Arbitration:
  - Combinational round-robin. Search starts at pointer p and proceeds p, p+1, ..., NUM_REQ-1, 0, ..., p-1.
  - The first i with req_valid[i] gets req_ready[i] = 1, provided en = 1 and not in reset. At most one ready bit is set.
  - Handshake: a transfer occurs at the edge where req_valid[i] and req_ready[i] are both high.
  - A requester must hold req_valid and req_x stable until it receives ready. It may drop valid before being granted with no effect.
  - On a transfer from requester g: pointer <= (g+1) mod NUM_REQ. With no transfer the pointer holds.
  - A single active requester is granted every cycle (throughput 1/cycle).
- Datapath drive:
  - On a transfer edge E0, {inv_x3, inv_x2, inv_x1} <= req_x[g].
  - With no transfer the drive holds its last value.
- Tag pipeline:
  - Depth DUT_LAT+1; each stage is {valid, id}. Stage 0 loads {1, g} at E0, else {0, x}. It shifts every cycle.
  - At edge E(DUT_LAT+1) the last stage is valid: rsp_y <= inv_y1 and rsp_valid <= onehot(id).
  - Otherwise rsp_valid <= 0 and rsp_y holds.
  - Response latency is DUT_LAT+1 cycles from the handshake edge. Back-to-back transfers yield back-to-back responses in issue order.
  - There is no response backpressure; requesters must accept rsp_valid whenever it fires.
- idle = no valid bit in the tag pipeline and rsp_valid = 0 (registered form is acceptable if it equals this expression).
- en low:
  - req_ready = 0 immediately (same cycle).
  - In-flight operations still complete and respond.
  - The pointer and inv_x* hold.
- Simultaneous requests: only the pointer-selected requester proceeds; the others wait with ready = 0.
- Pointer wrap: after granting NUM_REQ-1 the pointer returns to 0.
- Invalid encodings are impossible: ready and rsp_valid are at most one-hot; any violation is a bug and asserted in the bench.
- inv_y1 is sampled only at response edges; glitches between edges are ignored.

Test Plan:
- Reset/idle: rst_n = 0 then released, no requests → all outputs 0, idle = 1, inv_x* = 0 for 20 cycles.
- Single op (DUT_LAT = 1): requester 2 presents req_x = 3'b101 → req_ready = 4'b0100 the same cycle; inv_x3..x1 = 1,0,1 after the edge; rsp_valid = 4'b0100 two cycles after the handshake edge; rsp_y equals the bench model of `inv` for (X1=1, X2=0, X3=1).
- Round-robin fairness: all four requesters held valid with distinct operands → grants 0,1,2,3,0,1,... one per cycle; responses arrive in the same order, each carrying the correct result, with no gaps.
- Pointer rotation: requester 3 granted, then requesters 0 and 2 both valid → requester 0 granted first (search starts at 0 after wrap), then requester 2.
- Enable gating: en dropped while three ops are in flight → req_ready = 0 immediately; the three rsp_valid pulses still appear; idle = 1 afterwards; re-raising en resumes from the held pointer.
- Reset mid-operation: rst_n pulsed low for one half-cycle while two ops are in flight → no rsp_valid for either, pointer = 0, inv_x* = 0. The next request from requester 1 is granted with normal DUT_LAT+1 latency.
